onehot_decoder: RTL and testbench

ONEHOT_DECODER -- requirements
Module: onehot_decoder

---
 rtl/onehot_decoder_if.sv | 20 ++
 rtl/onehot_decoder.sv | 134 +++++++++++++
 tb/tb_onehot_decoder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_decoder_if.sv
// Request handshake bundle for onehot_decoder.
// Carries the binary code, the no-request flag and valid/ready.
interface onehot_decoder_if;
  logic y2;
  logic y1;
  logic y0;
  logic y;
  logic in_valid;
  logic in_ready;

  modport master (
    output y2, y1, y0, y, in_valid,
    input  in_ready
  );

  modport slave (
    input  y2, y1, y0, y, in_valid,
    output in_ready
  );
endinterface

// File: rtl/onehot_decoder.sv
// Queued binary-to-one-hot decoder: each code drives one line of h
// for HOLD cycles, followed by GAP idle cycles, through a 2-deep FIFO.
module onehot_decoder #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  onehot_decoder_if.slave   in_if,
  output logic [7:0]        h,
  output logic              busy,
  output logic [7:0]        none_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] GAP_S = 2'd2;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
  localparam logic [7:0] GAP_M1  =
    (GAP == 0) ? 8'd0 : 8'(GAP - 1);
  localparam bit HAS_GAP = (GAP != 0);

  logic [1:0] state;
  logic [7:0] hold_cnt;
  logic [7:0] gap_cnt;

  logic [2:0] fifo_q [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  logic [2:0] code;
  logic [2:0] head;
  logic [7:0] head_oh;
  logic       accept;
  logic       push;
  logic       pop;
  logic       drop;
  logic       hold_done;

  assign code    = {in_if.y2, in_if.y1, in_if.y0};
  assign in_if.in_ready = (count != 2'd2);
  assign accept  = in_if.in_valid & in_if.in_ready;
  assign push    = accept & ~in_if.y;
  assign drop    = accept & in_if.y;
  assign head    = fifo_q[rd_ptr];
  assign head_oh = 8'd1 << head;
  assign busy    = (state != IDLE) | (count != 2'd0);
  assign hold_done = (hold_cnt == 8'd0);

  // Pops happen only where a new code is loaded into h.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = (count != 2'd0);
      DRIVE:   pop = hold_done & ~HAS_GAP
                   & (count != 2'd0);
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= 3'd0;
      fifo_q[1] <= 3'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= code;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      h        <= 8'd0;
      hold_cnt <= 8'd0;
      gap_cnt  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            h        <= head_oh;
            hold_cnt <= HOLD_M1;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          if (!hold_done) begin
            hold_cnt <= hold_cnt - 8'd1;
          end else if (HAS_GAP) begin
            h       <= 8'd0;
            gap_cnt <= GAP_M1;
            state   <= GAP_S;
          end else if (pop) begin
            h        <= head_oh;
            hold_cnt <= HOLD_M1;
          end else begin
            h     <= 8'd0;
            state <= IDLE;
          end
        end
        GAP_S: begin
          if (gap_cnt == 8'd0) state <= IDLE;
          else gap_cnt <= gap_cnt - 8'd1;
        end
        default: begin
          h     <= 8'd0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      none_cnt <= 8'd0;
    end else if (drop && none_cnt != 8'hff) begin
      none_cnt <= none_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_onehot_decoder.sv
// Bench for onehot_decoder: three parameterisations driven in
// parallel and compared each cycle against a queue/timer model.
module tb_onehot_decoder;

  logic clk;
  logic rst_n;

  onehot_decoder_if if0 ();
  onehot_decoder_if if1 ();
  onehot_decoder_if if2 ();

  logic [7:0] h_o    [3];
  logic       busy_o [3];
  logic [7:0] none_o [3];
  logic       rdy_o  [3];

  onehot_decoder #(.HOLD(4), .GAP(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_if(if0.slave),
    .h(h_o[0]), .busy(busy_o[0]), .none_cnt(none_o[0])
  );
  onehot_decoder #(.HOLD(4), .GAP(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_if(if1.slave),
    .h(h_o[1]), .busy(busy_o[1]), .none_cnt(none_o[1])
  );
  onehot_decoder #(.HOLD(1), .GAP(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_if(if2.slave),
    .h(h_o[2]), .busy(busy_o[2]), .none_cnt(none_o[2])
  );

  assign rdy_o[0] = if0.in_ready;
  assign rdy_o[1] = if1.in_ready;
  assign rdy_o[2] = if2.in_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // stimulus per DUT
  bit sv [3];
  int sc [3];
  bit sy [3];

  // model: queued codes, remaining drive / gap cycles
  int         m_q    [3][2];
  int         m_cnt  [3];
  int         m_out  [3];
  int         m_gap  [3];
  logic [7:0] m_h    [3];
  int         m_none [3];

  function automatic int hold_of(int d);
    return (d == 2) ? 1 : 4;
  endfunction

  function automatic int gap_of(int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      m_cnt[d]  = 0;
      m_out[d]  = 0;
      m_gap[d]  = 0;
      m_h[d]    = 8'd0;
      m_none[d] = 0;
    end
  endfunction

  function automatic void model_load(int d);
    m_h[d]    = 8'(1 << m_q[d][0]);
    m_q[d][0] = m_q[d][1];
    m_cnt[d]  = m_cnt[d] - 1;
    m_out[d]  = hold_of(d);
  endfunction

  function automatic void model_edge(int d);
    bit rdy;
    rdy = (m_cnt[d] < 2);
    if (m_out[d] > 1) begin
      m_out[d]--;
    end else if (m_out[d] == 1) begin
      m_out[d] = 0;
      m_h[d]   = 8'd0;
      if (gap_of(d) > 0) m_gap[d] = gap_of(d);
      else if (m_cnt[d] > 0) model_load(d);
    end else if (m_gap[d] > 0) begin
      m_gap[d]--;
    end else if (m_cnt[d] > 0) begin
      model_load(d);
    end
    if (sv[d] && rdy) begin
      if (sy[d]) begin
        if (m_none[d] < 255) m_none[d]++;
      end else begin
        m_q[d][m_cnt[d]] = sc[d];
        m_cnt[d]++;
      end
    end
  endfunction

  task automatic cmp(string tag, logic [7:0] obs,
                     logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit b;
    for (int d = 0; d < 3; d++) begin
      b = (m_out[d] > 0) || (m_gap[d] > 0) || (m_cnt[d] > 0);
      cmp($sformatf("h%0d", d), h_o[d], m_h[d]);
      cmp($sformatf("busy%0d", d), 8'(busy_o[d]), 8'(b));
      cmp($sformatf("none%0d", d), none_o[d], 8'(m_none[d]));
      cmp($sformatf("rdy%0d", d), 8'(rdy_o[d]),
          8'(m_cnt[d] < 2));
    end
  endtask

  task automatic drive();
    if0.in_valid = sv[0]; if0.y = sy[0];
    {if0.y2, if0.y1, if0.y0} = 3'(sc[0]);
    if1.in_valid = sv[1]; if1.y = sy[1];
    {if1.y2, if1.y1, if1.y0} = 3'(sc[1]);
    if2.in_valid = sv[2]; if2.y = sy[2];
    {if2.y2, if2.y1, if2.y0} = 3'(sc[2]);
  endtask

  task automatic step();
    drive();
    for (int d = 0; d < 3; d++) model_edge(d);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_all(bit v, int c, bit yy);
    for (int d = 0; d < 3; d++) begin
      sv[d] = v; sc[d] = c; sy[d] = yy;
    end
  endtask

  task automatic idle(int n);
    set_all(1'b0, 0, 1'b0);
    for (int i = 0; i < n; i++) step();
  endtask

  // each DUT walks the list independently, valid held high
  task automatic push_list(int n, int c0, int c1, int c2);
    int idx [3];
    bit acc [3];
    int lst [3];
    lst[0] = c0; lst[1] = c1; lst[2] = c2;
    for (int d = 0; d < 3; d++) idx[d] = 0;
    for (int t = 0; t < 60; t++) begin
      if (idx[0] >= n && idx[1] >= n && idx[2] >= n) break;
      for (int d = 0; d < 3; d++) begin
        sv[d]  = (idx[d] < n);
        sc[d]  = (idx[d] < n) ? lst[idx[d]] : 0;
        sy[d]  = 1'b0;
        acc[d] = sv[d] && (m_cnt[d] < 2);
      end
      step();
      for (int d = 0; d < 3; d++) if (acc[d]) idx[d]++;
    end
    for (int d = 0; d < 3; d++)
      cmp($sformatf("push_done%0d", d), 8'(idx[d]), 8'(n));
    set_all(1'b0, 0, 1'b0);
  endtask

  task automatic check_reset_vals(string tag);
    for (int d = 0; d < 3; d++) begin
      cmp($sformatf("%s_h%0d", tag, d), h_o[d], 8'h00);
      cmp($sformatf("%s_busy%0d", tag, d),
          8'(busy_o[d]), 8'h00);
      cmp($sformatf("%s_rdy%0d", tag, d),
          8'(rdy_o[d]), 8'h01);
      cmp($sformatf("%s_none%0d", tag, d), none_o[d], 8'h00);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    set_all(1'b0, 0, 1'b0);
    drive();
    rst_n = 1'b0;
    #2;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // single code 5: latency one edge, then HOLD cycles
    set_all(1'b1, 5, 1'b0);
    step();
    cmp("lat_k", h_o[0], 8'h00);
    idle(1);
    cmp("lat_k1", h_o[0], 8'h20);
    idle(3);
    cmp("hold_end", h_o[0], 8'h20);
    idle(1);
    cmp("gap_h", h_o[0], 8'h00);
    cmp("gap_busy", 8'(busy_o[0]), 8'h01);
    idle(1);
    cmp("idle_busy", 8'(busy_o[0]), 8'h00);
    idle(4);

    // fill the FIFO with valid held high
    push_list(3, 1, 6, 3);
    idle(30);
    // back-to-back loads
    push_list(2, 0, 7, 0);
    idle(20);
    push_list(2, 2, 4, 0);
    idle(20);

    // discarded requests, then saturation
    set_all(1'b1, 7, 1'b1);
    step();
    idle(2);
    cmp("none_one", none_o[0], 8'h01);
    set_all(1'b1, 7, 1'b1);
    for (int i = 0; i < 300; i++) step();
    idle(2);
    cmp("none_sat", none_o[1], 8'hff);

    // async reset while driving with two codes queued
    push_list(3, 5, 6, 7);
    cmp("pre_rst_h", h_o[0], 8'h20);
    cmp("pre_rst_rdy", 8'(rdy_o[0]), 8'h00);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_vals("arst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(12);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      for (int d = 0; d < 3; d++) begin
        sv[d] = ($urandom_range(0, 2) != 0);
        sc[d] = $urandom_range(0, 7);
        sy[d] = ($urandom_range(0, 3) == 0);
      end
      step();
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
